float2int_ext: RTL and testbench
================================

# float2int_ext

Parametrised IEEE-754 single-precision to integer converter, successor to the fixed 32-bit signed converter in the DSA arithmetic library. It adds a configurable result width, per-transaction signed/unsigned mode and rounding mode, correct saturation in both directions, and exception flags. It sits between float producers and integer datapaths and uses the library's stb/ack handshake on both sides. Conversion is iterative, with one alignment shift per cycle.

## Interface
- OUT_W, 32, result width in bits; legal range 8..64.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- input_a  in  32  IEEE-754 binary32 operand.
- input_signed  in  1  1 = signed two's-complement result, 0 = unsigned; sampled with input_a.
- input_rnd  in  1  0 = truncate toward zero, 1 = round-to-nearest-even; sampled with input_a.
- input_a_stb  in  1  operand valid.
- input_a_ack  out  1  converter ready; transfer occurs when input_a_stb and input_a_ack are both high on a clock edge.
- output_z  out  OUT_W  integer result.
- output_flags  out  3  {invalid, overflow, inexact}; valid with output_z.
- output_z_stb  out  1  result valid.
- output_z_ack  in  1  consumer accepts; transfer occurs when output_z_stb and output_z_ack are both high.

## Operation
- States: get_a, unpack, special_cases, align, round, put_z.
- get_a: register input_a_ack to 1. On transfer, capture input_a, input_signed and input_rnd, clear input_a_ack, and go to unpack.
- unpack: set sign s, unbiased exponent e = exp-127 (10-bit signed), and mantissa m = {hidden, frac}. The hidden bit is 0 when exp = 0. Clear guard and sticky.
- special_cases, first matching rule wins:
  - NaN: z = 0, invalid.
  - Inf: saturate, overflow.
  - Zero: z = 0, no flags.
  - Denormal or e < -1: z = 0, inexact. Rounding is not needed because the magnitude is below 0.5.
  - Signed and e > OUT_W-1, or signed and e = OUT_W-1 except for exactly -2^(OUT_W-1): saturate, overflow.
  - Unsigned and e >= OUT_W: saturate, overflow.
  - Otherwise go to align.
- Saturation values:
  - Signed: +2^(OUT_W-1)-1 for positive, -2^(OUT_W-1) for negative.
  - Unsigned: 2^OUT_W-1 for positive, 0 for negative.
- align: the working magnitude register is max(OUT_W,24)+1 bits.
  - Perform one shift per cycle until the pending count reaches 0, then go to round.
  - e > 23: left-shift e-23 times.
  - e < 23: right-shift 23-e times. Bit shifted out goes to guard; the old guard ORs into sticky.
- round:
  - inexact = guard|sticky.
  - RNE increments when guard & (sticky | lsb).
  - Truncate never increments.
- Post-round magnitude checks:
  - Signed overflows if magnitude > 2^(OUT_W-1)-1, except a negative value with magnitude exactly 2^(OUT_W-1).
  - Unsigned overflows if magnitude > 2^OUT_W-1.
  - On overflow, saturate and set overflow.
- Unsigned negative input:
  - Rounded magnitude nonzero: z = 0, overflow.
  - Rounded magnitude zero: z = 0, inexact only.
- Signed negative input: z = -magnitude, truncated to OUT_W bits.
- On overflow, the inexact flag is cleared.
- put_z: register output_z_stb = 1, plus output_z and output_flags. On transfer, clear output_z_stb and go to get_a.

## Timing
- Reset values: input_a_ack 0, output_z_stb 0, output_z 0, output_flags 0, state get_a.
- Reset is applied at any cycle, including mid-align or mid-put_z. It aborts the current conversion. The result is never presented, and input_a_ack reasserts 1 cycle after reset deasserts.
- input_a_ack rises 1 cycle after entry to get_a, so the minimum gap between transfers is 2 cycles after output accept.
- Latency is counted from the input transfer edge (cycle 0):
  - Special-case result: output_z_stb is high from cycle 4.
  - Aligned result: output_z_stb is high from cycle 6+N, where N = |e-23|.
  - Worst case at OUT_W = 64 is 46.
- Output backpressure: output_z, output_flags and output_z_stb stay stable until the accept edge. input_a_ack stays 0 during this time.
- input_signed and input_rnd are ignored except at the transfer edge.

## Test plan
- OUT_W=32, signed, truncate: 0x40600000 (3.5) -> 3, flags 001.
- OUT_W=32, signed, RNE: 3.5 -> 4, flags 001; 0x40200000 (2.5) -> 2, flags 001.
- OUT_W=32, signed:
  - 0xCF000000 -> 0x80000000, flags 000.
  - 0x4F000000 -> 0x7FFFFFFF, flags 010.
- OUT_W=32, unsigned:
  - 0x4F000000 -> 0x80000000, flags 000.
  - 0x7F800000 -> 0xFFFFFFFF, flags 010.
  - 0xBF800000 (-1.0) -> 0, flags 010.
  - 0xBE800000 (-0.25) -> 0, flags 001.
- OUT_W=32, NaN 0x7FC00000 (either mode) -> 0, flags 100.
- OUT_W=32, -0.0 0x80000000 -> 0, flags 000.
- OUT_W=16, unsigned, RNE: 0x477FFF80 (65535.5) -> 0xFFFF, flags 010; with truncate -> 0xFFFF, flags 001.
- OUT_W=64, signed: 0x5E800000 (2^62) -> 0x4000000000000000, flags 000, stb at cycle 45.
- Handshake and reset:
  - Hold output_z_ack low 10 cycles: output_z and stb stable, input_a_ack stays 0.
  - Assert rst during align: stb stays 0, and the next operand converts correctly.

Source files
------------

// File: rtl/float2int_ext.sv
// Iterative binary32 -> OUT_W-bit integer converter with stb/ack handshakes, latency 4 (special) or 6+|e-23| cycles.
// The result is held with output_z_stb high until accepted; input_a_ack stays low for the whole conversion.
module float2int_ext #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      input_a,
  input  logic             input_signed,
  input  logic             input_rnd,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  output logic [OUT_W-1:0] output_z,
  output logic [2:0]       output_flags,
  output logic             output_z_stb,
  input  logic             output_z_ack
);

  localparam int MW = ((OUT_W > 24) ? OUT_W : 24) + 1;
  localparam logic signed [9:0] E_TOP = 10'(OUT_W - 1);
  localparam logic [MW-1:0] LIM_S = {{(MW-1){1'b0}}, 1'b1} << (OUT_W - 1);
  localparam logic [MW-1:0] LIM_U = {{(MW-1){1'b0}}, 1'b1} << OUT_W;

  typedef enum logic [2:0] {
    S_GET_A, S_UNPACK, S_SPECIAL, S_ALIGN, S_ROUND, S_PUT_Z
  } state_t;

  state_t            state_q, state_d;
  logic              ack_q, ack_d;
  logic              stb_q, stb_d;
  logic [31:0]       a_q, a_d;
  logic              sgn_q, sgn_d;
  logic              rnd_q, rnd_d;
  logic              s_q, s_d;
  logic signed [9:0] e_q, e_d;
  logic [MW-1:0]     mag_q, mag_d;
  logic              guard_q, guard_d;
  logic              sticky_q, sticky_d;
  logic [6:0]        cnt_q, cnt_d;
  logic              left_q, left_d;
  logic [OUT_W-1:0]  z_q, z_d;
  logic [2:0]        flags_q, flags_d;

  logic [MW-1:0]     mag_r;
  logic              inc, inexact, ovf, frac_nz, exp_max, exp_zero;

  function automatic logic [OUT_W-1:0] sat_val(input logic neg, input logic sgnd);
    logic [OUT_W-1:0] v;
    if (sgnd) v = neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else      v = neg ? '0 : '1;
    return v;
  endfunction

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    stb_d    = stb_q;
    a_d      = a_q;
    sgn_d    = sgn_q;
    rnd_d    = rnd_q;
    s_d      = s_q;
    e_d      = e_q;
    mag_d    = mag_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    z_d      = z_q;
    flags_d  = flags_q;
    frac_nz  = (a_q[22:0] != 23'd0);
    exp_max  = (a_q[30:23] == 8'hFF);
    exp_zero = (a_q[30:23] == 8'h00);
    inc      = rnd_q & guard_q & (sticky_q | mag_q[0]);
    inexact  = guard_q | sticky_q;
    mag_r    = mag_q + {{(MW-1){1'b0}}, inc};
    ovf      = sgn_q ? ((mag_r >= LIM_S) && !(s_q && (mag_r == LIM_S))) : (mag_r >= LIM_U);

    case (state_q)
      S_GET_A: begin
        ack_d = 1'b1;
        if (ack_q && input_a_stb) begin
          a_d     = input_a;
          sgn_d   = input_signed;
          rnd_d   = input_rnd;
          ack_d   = 1'b0;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        s_d      = a_q[31];
        e_d      = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        mag_d    = MW'({!exp_zero, a_q[22:0]});
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        state_d  = S_SPECIAL;
      end
      S_SPECIAL: begin
        state_d = S_PUT_Z;
        if (exp_max && frac_nz) begin
          z_d = '0; flags_d = 3'b100;
        end else if (exp_max) begin
          z_d = sat_val(s_q, sgn_q); flags_d = 3'b010;
        end else if (exp_zero && !frac_nz) begin
          z_d = '0; flags_d = 3'b000;
        end else if (exp_zero || (e_q < -10'sd1)) begin
          z_d = '0; flags_d = 3'b001;
        end else if (sgn_q && ((e_q > E_TOP) || ((e_q == E_TOP) && !(s_q && !frac_nz)))) begin
          z_d = sat_val(s_q, 1'b1); flags_d = 3'b010;
        end else if (!sgn_q && (e_q > E_TOP)) begin
          z_d = sat_val(s_q, 1'b0); flags_d = 3'b010;
        end else begin
          state_d = S_ALIGN;
          left_d  = (e_q > 10'sd23);
          cnt_d   = (e_q > 10'sd23) ? 7'(e_q - 10'sd23) : 7'(10'sd23 - e_q);
        end
      end
      S_ALIGN: begin
        if (cnt_q == 7'd0) begin
          state_d = S_ROUND;
        end else begin
          cnt_d = cnt_q - 7'd1;
          if (left_q) begin
            mag_d = mag_q << 1;
          end else begin
            // Last bit out is the guard; everything shifted out earlier folds into sticky.
            mag_d    = mag_q >> 1;
            guard_d  = mag_q[0];
            sticky_d = sticky_q | guard_q;
          end
        end
      end
      S_ROUND: begin
        state_d = S_PUT_Z;
        if (ovf) begin
          z_d = sat_val(s_q, sgn_q); flags_d = 3'b010;
        end else if (!sgn_q && s_q) begin
          z_d     = '0;
          flags_d = (mag_r != '0) ? 3'b010 : {2'b00, inexact};
        end else begin
          z_d     = s_q ? -mag_r[OUT_W-1:0] : mag_r[OUT_W-1:0];
          flags_d = {2'b00, inexact};
        end
      end
      S_PUT_Z: begin
        stb_d = 1'b1;
        if (stb_q && output_z_ack) begin
          stb_d   = 1'b0;
          state_d = S_GET_A;
        end
      end
      default: state_d = S_GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_GET_A;
      ack_q    <= 1'b0;
      stb_q    <= 1'b0;
      a_q      <= '0;
      sgn_q    <= 1'b0;
      rnd_q    <= 1'b0;
      s_q      <= 1'b0;
      e_q      <= '0;
      mag_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      z_q      <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      stb_q    <= stb_d;
      a_q      <= a_d;
      sgn_q    <= sgn_d;
      rnd_q    <= rnd_d;
      s_q      <= s_d;
      e_q      <= e_d;
      mag_q    <= mag_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      z_q      <= z_d;
      flags_q  <= flags_d;
    end
  end

  assign input_a_ack  = ack_q;
  assign output_z_stb = stb_q;
  assign output_z     = z_q;
  assign output_flags = flags_q;

endmodule

// File: tb/tb_float2int_ext.sv
// Bench for float2int_ext at OUT_W = 16, 32 and 64 against a real-arithmetic reference model.
// Latency L means output_z_stb is high at the L-th rising edge after the input transfer edge.
module tb_float2int_ext;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] a   = '0;
  logic        sgn = 1'b0, rnd = 1'b0;
  logic        stb16 = 1'b0, stb32 = 1'b0, stb64 = 1'b0;
  logic        zack16 = 1'b0, zack32 = 1'b0, zack64 = 1'b0;
  logic        ack16, ack32, ack64, zstb16, zstb32, zstb64;
  logic [15:0] z16;
  logic [31:0] z32;
  logic [63:0] z64;
  logic [2:0]  fl16, fl32, fl64;
  int          n_cmp = 0, n_bad = 0;

  float2int_ext #(.OUT_W(16)) dut16 (.clk(clk), .rst(rst), .input_a(a), .input_signed(sgn),
    .input_rnd(rnd), .input_a_stb(stb16), .input_a_ack(ack16), .output_z(z16),
    .output_flags(fl16), .output_z_stb(zstb16), .output_z_ack(zack16));
  float2int_ext #(.OUT_W(32)) dut32 (.clk(clk), .rst(rst), .input_a(a), .input_signed(sgn),
    .input_rnd(rnd), .input_a_stb(stb32), .input_a_ack(ack32), .output_z(z32),
    .output_flags(fl32), .output_z_stb(zstb32), .output_z_ack(zack32));
  float2int_ext #(.OUT_W(64)) dut64 (.clk(clk), .rst(rst), .input_a(a), .input_signed(sgn),
    .input_rnd(rnd), .input_a_stb(stb64), .input_a_ack(ack64), .output_z(z64),
    .output_flags(fl64), .output_z_stb(zstb64), .output_z_ack(zack64));

  typedef struct packed {
    logic [6:0]  w;
    logic [31:0] x;
    logic        sg;
    logic        rd;
    logic [63:0] z;
    logic [2:0]  fl;
    logic [5:0]  lat;
  } vec_t;

  vec_t tbl [16] = '{
    '{7'd32, 32'h40600000, 1'b1, 1'b0, 64'd3,                  3'b001, 6'd28},
    '{7'd32, 32'h40600000, 1'b1, 1'b1, 64'd4,                  3'b001, 6'd28},
    '{7'd32, 32'h40200000, 1'b1, 1'b1, 64'd2,                  3'b001, 6'd28},
    '{7'd32, 32'hCF000000, 1'b1, 1'b0, 64'h80000000,           3'b000, 6'd14},
    '{7'd32, 32'h4F000000, 1'b1, 1'b0, 64'h7FFFFFFF,           3'b010, 6'd4},
    '{7'd32, 32'h4F000000, 1'b0, 1'b0, 64'h80000000,           3'b000, 6'd14},
    '{7'd32, 32'h7F800000, 1'b0, 1'b0, 64'hFFFFFFFF,           3'b010, 6'd4},
    '{7'd32, 32'hBF800000, 1'b0, 1'b0, 64'd0,                  3'b010, 6'd29},
    '{7'd32, 32'hBE800000, 1'b0, 1'b0, 64'd0,                  3'b001, 6'd4},
    '{7'd32, 32'h7FC00000, 1'b1, 1'b0, 64'd0,                  3'b100, 6'd4},
    '{7'd32, 32'h7FC00000, 1'b0, 1'b1, 64'd0,                  3'b100, 6'd4},
    '{7'd32, 32'h80000000, 1'b1, 1'b0, 64'd0,                  3'b000, 6'd4},
    '{7'd16, 32'h477FFF80, 1'b0, 1'b1, 64'hFFFF,               3'b010, 6'd14},
    '{7'd16, 32'h477FFF80, 1'b0, 1'b0, 64'hFFFF,               3'b001, 6'd14},
    '{7'd64, 32'h5E800000, 1'b1, 1'b0, 64'h4000000000000000,   3'b000, 6'd45},
    '{7'd64, 32'hDF000000, 1'b1, 1'b0, 64'h8000000000000000,   3'b000, 6'd46}
  };

  function automatic logic in_ack(int w);
    case (w) 16: return ack16; 64: return ack64; default: return ack32; endcase
  endfunction
  function automatic logic out_stb(int w);
    case (w) 16: return zstb16; 64: return zstb64; default: return zstb32; endcase
  endfunction
  function automatic logic [63:0] out_z(int w);
    case (w) 16: return {48'd0, z16}; 64: return z64; default: return {32'd0, z32}; endcase
  endfunction
  function automatic logic [2:0] out_fl(int w);
    case (w) 16: return fl16; 64: return fl64; default: return fl32; endcase
  endfunction
  task automatic drive_stb(input int w, input logic v);
    case (w) 16: stb16 = v; 64: stb64 = v; default: stb32 = v; endcase
  endtask
  task automatic drive_zack(input int w, input logic v);
    case (w) 16: zack16 = v; 64: zack64 = v; default: zack32 = v; endcase
  endtask

  // Reference: exact value of the float in real arithmetic, then saturation/rounding rules.
  function automatic void model(input int w, input logic [31:0] x, input logic sg, input logic rd,
                                output logic [63:0] z, output logic [2:0] fl);
    int ex, fi;
    logic neg, inexact, pre, ovf;
    real mag, t, fr, lim_s, lim_u, p;
    logic [63:0] mask, sat, zi;
    ex = int'(x[30:23]);
    fi = int'(x[22:0]);
    neg = x[31];
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (sg) sat = neg ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
    else    sat = neg ? 64'd0 : mask;
    lim_s = 2.0 ** real'(w - 1);
    lim_u = 2.0 ** real'(w);
    if (ex == 255) begin
      z  = (fi != 0) ? 64'd0 : sat;
      fl = (fi != 0) ? 3'b100 : 3'b010;
      return;
    end
    if (ex == 0) mag = real'(fi) * (2.0 ** (-149.0));
    else         mag = real'(fi + (1 << 23)) * (2.0 ** real'(ex - 150));
    pre = sg ? ((mag >= lim_s) && !(neg && mag == lim_s)) : (mag >= lim_u);
    t = $floor(mag);
    fr = mag - t;
    inexact = (fr != 0.0);
    if (rd && ((fr > 0.5) || (fr == 0.5 && (t - 2.0 * $floor(t / 2.0)) != 0.0))) t = t + 1.0;
    ovf = sg ? ((t >= lim_s) && !(neg && t == lim_s)) : (t >= lim_u);
    if (pre || ovf) begin
      z = sat; fl = 3'b010;
    end else if (!sg && neg) begin
      z = 64'd0; fl = (t != 0.0) ? 3'b010 : {2'b00, inexact};
    end else begin
      zi = '0;
      for (int i = 63; i >= 0; i--) begin
        p = 2.0 ** real'(i);
        if (t >= p) begin zi[i] = 1'b1; t = t - p; end
      end
      z  = neg ? ((~zi + 64'd1) & mask) : zi;
      fl = {2'b00, inexact};
    end
  endfunction

  function automatic int exp_latency(input int w, input logic [31:0] x, input logic sg);
    int ex, e;
    ex = int'(x[30:23]);
    e  = ex - 127;
    if (ex == 255 || ex == 0 || e < -1) return 4;
    if (sg && (e > w - 1 || (e == w - 1 && !(x[31] && x[22:0] == 23'd0)))) return 4;
    if (!sg && e >= w) return 4;
    return 6 + ((e > 23) ? (e - 23) : (23 - e));
  endfunction

  // Hands one operand over and waits for the result; leaves output_z_ack low.
  task automatic convert(input int w, input logic [31:0] x, input logic sg, input logic rd,
                         output logic [63:0] z, output logic [2:0] fl, output int lat, output bit ok);
    int k;
    ok = 1'b0; lat = -1; z = '0; fl = '0;
    @(negedge clk);
    a = x; sgn = sg; rnd = rd;
    drive_stb(w, 1'b1);
    k = 0;
    while (!in_ack(w) && k < 60) begin @(negedge clk); k++; end
    if (!in_ack(w)) begin drive_stb(w, 1'b0); return; end
    @(posedge clk);
    #1;
    drive_stb(w, 1'b0);
    a = $urandom; sgn = 1'($urandom); rnd = 1'($urandom);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_stb(w)) begin lat = i + 1; ok = 1'b1; break; end
    end
    z = out_z(w);
    fl = out_fl(w);
  endtask

  task automatic accept(input int w);
    drive_zack(w, 1'b1);
    @(posedge clk);
    #1;
    drive_zack(w, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({ack16, ack32, ack64} !== 3'b000) begin n_bad++; $display("FAIL reset_ack got %b want 000", {ack16, ack32, ack64}); end
    n_cmp++; if ({zstb16, zstb32, zstb64} !== 3'b000) begin n_bad++; $display("FAIL reset_stb got %b want 000", {zstb16, zstb32, zstb64}); end
    n_cmp++; if ({z16, z32, z64} !== 112'd0) begin n_bad++; $display("FAIL reset_z got %h want 0", {z16, z32, z64}); end
    n_cmp++; if ({fl16, fl32, fl64} !== 9'd0) begin n_bad++; $display("FAIL reset_flags got %b want 0", {fl16, fl32, fl64}); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ack32 !== 1'b0) begin n_bad++; $display("FAIL reset_ack_early got %b want 0", ack32); end
    @(negedge clk);
    n_cmp++; if (ack32 !== 1'b1) begin n_bad++; $display("FAIL reset_ack_rise got %b want 1", ack32); end
  endtask

  task automatic test_directed();
    logic [63:0] z;
    logic [2:0] fl;
    int lat, w;
    bit ok;
    foreach (tbl[i]) begin
      w = int'(tbl[i].w);
      convert(w, tbl[i].x, tbl[i].sg, tbl[i].rd, z, fl, lat, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL dir%0d_timeout got no stb want stb", i); continue; end
      accept(w);
      n_cmp++; if (z !== tbl[i].z) begin n_bad++; $display("FAIL dir%0d_z got %h want %h", i, z, tbl[i].z); end
      n_cmp++; if (fl !== tbl[i].fl) begin n_bad++; $display("FAIL dir%0d_flags got %b want %b", i, fl, tbl[i].fl); end
      n_cmp++; if (lat !== int'(tbl[i].lat)) begin n_bad++; $display("FAIL dir%0d_lat got %0d want %0d", i, lat, tbl[i].lat); end
    end
  endtask

  task automatic test_random();
    logic [63:0] z, ez;
    logic [2:0] fl, efl;
    logic [31:0] x;
    logic [7:0] ex;
    logic [22:0] fr;
    int lat, w, r;
    bit ok, sg, rd;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 2);
      w = (r == 0) ? 16 : ((r == 1) ? 32 : 64);
      r = $urandom_range(0, 9);
      ex = (r < 7) ? 8'($urandom_range(118, 200)) : ((r == 7) ? ($urandom_range(0, 1) ? 8'hFF : 8'h00) : 8'($urandom));
      fr = 23'($urandom);
      if ($urandom_range(0, 3) == 0) fr = fr & (23'h7FFFFF << $urandom_range(0, 22));
      x = {1'($urandom), ex, fr};
      sg = 1'($urandom);
      rd = 1'($urandom);
      model(w, x, sg, rd, ez, efl);
      convert(w, x, sg, rd, z, fl, lat, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL rnd%0d_timeout x=%h got no stb want stb", i, x); continue; end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      accept(w);
      n_cmp++; if (z !== ez) begin n_bad++; $display("FAIL rnd%0d_z w=%0d x=%h s=%b r=%b got %h want %h", i, w, x, sg, rd, z, ez); end
      n_cmp++; if (fl !== efl) begin n_bad++; $display("FAIL rnd%0d_flags w=%0d x=%h got %b want %b", i, w, x, fl, efl); end
      n_cmp++; if (lat !== exp_latency(w, x, sg)) begin n_bad++; $display("FAIL rnd%0d_lat w=%0d x=%h got %0d want %0d", i, w, x, lat, exp_latency(w, x, sg)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] z, ez;
    logic [2:0] fl, efl;
    int lat;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      model(32, 32'h42F6E979 ^ 32'(i << 20), 1'b1, 1'b1, ez, efl);
      convert(32, 32'h42F6E979 ^ 32'(i << 20), 1'b1, 1'b1, z, fl, lat, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL b2b%0d_timeout got no stb want stb", i); continue; end
      n_cmp++; if ({z, fl} !== {ez, efl}) begin n_bad++; $display("FAIL b2b%0d_result got %h/%b want %h/%b", i, z, fl, ez, efl); end
      accept(32);
      @(negedge clk);
      n_cmp++; if (ack32 !== 1'b0) begin n_bad++; $display("FAIL b2b%0d_ack_gap got %b want 0", i, ack32); end
      @(negedge clk);
      n_cmp++; if (ack32 !== 1'b1) begin n_bad++; $display("FAIL b2b%0d_ack_rise got %b want 1", i, ack32); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] z;
    logic [2:0] fl;
    int lat;
    bit ok;
    convert(32, 32'h40600000, 1'b1, 1'b0, z, fl, lat, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL bp_timeout got no stb want stb"); return; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if (zstb32 !== 1'b1) begin n_bad++; $display("FAIL bp%0d_stb got %b want 1", i, zstb32); end
      n_cmp++; if (z32 !== 32'd3) begin n_bad++; $display("FAIL bp%0d_z got %h want 3", i, z32); end
      n_cmp++; if (fl32 !== 3'b001) begin n_bad++; $display("FAIL bp%0d_flags got %b want 001", i, fl32); end
      n_cmp++; if (ack32 !== 1'b0) begin n_bad++; $display("FAIL bp%0d_in_ack got %b want 0", i, ack32); end
    end
    accept(32);
    @(negedge clk);
    n_cmp++; if (zstb32 !== 1'b0) begin n_bad++; $display("FAIL bp_stb_drop got %b want 0", zstb32); end
  endtask

  task automatic test_reset_mid_align();
    logic [63:0] z;
    logic [2:0] fl;
    int lat, k;
    bit ok, seen;
    @(negedge clk);
    a = 32'h3F000000; sgn = 1'b1; rnd = 1'b1;
    stb32 = 1'b1;
    k = 0;
    while (!ack32 && k < 60) begin @(negedge clk); k++; end
    n_cmp++; if (ack32 !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ack got %b want 1", ack32); end
    @(posedge clk);
    #1 stb32 = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | zstb32;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stb got %b want 0", seen); end
    convert(32, 32'h40600000, 1'b1, 1'b1, z, fl, lat, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rst_mid_timeout got no stb want stb"); return; end
    accept(32);
    n_cmp++; if ({z, fl} !== {64'd4, 3'b001}) begin n_bad++; $display("FAIL rst_mid_result got %h/%b want 4/001", z, fl); end
    n_cmp++; if (lat !== 28) begin n_bad++; $display("FAIL rst_mid_lat got %0d want 28", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_align();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
